// File: rtl/fetch_unit.sv
// PC / instruction-fetch stage: fetches via iREN/ihit, holds the word for decode,
// and advances the PC from PCSrc. It stalls on data accesses until dhit and stops on halt.
module fetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] imemaddr,
  output logic [31:0] instruction,
  output logic        instr_valid,
  input  logic [2:0]  PCSrc,
  input  logic [31:0] jr_target,
  input  logic        mem_op,
  input  logic        dhit,
  input  logic        halt,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        commit,
  output logic        halted
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    EXEC    = 2'd1,
    MEMWAIT = 2'd2,
    HALT    = 2'd3
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] instr_q;
  logic        valid_q;
  logic        halted_q;

  assign pc          = pc_q;
  assign imemaddr    = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign halted      = halted_q;
  assign iREN        = (state_q == FETCH);

  // Retire strobe; reset suppresses it so a reset cycle never writes the register file.
  assign commit = !RST &&
                  (((state_q == EXEC) && !halt && !mem_op) ||
                   ((state_q == MEMWAIT) && dhit));

  always_comb begin
    pc_d = pc_plus4;
    case (PCSrc)
      3'd0:    pc_d = jr_target;
      3'd1:    pc_d = {pc_plus4[31:28], instr_q[25:0], 2'b00};
      3'd2:    pc_d = pc_plus4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
      default: pc_d = pc_plus4;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= FETCH;
      pc_q     <= PC_INIT;
      instr_q  <= 32'd0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (ihit) begin
            instr_q <= imemload;
            valid_q <= 1'b1;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (halt) begin
            halted_q <= 1'b1;
            state_q  <= HALT;
          end else if (mem_op) begin
            pc_q    <= pc_d;
            state_q <= MEMWAIT;
          end else begin
            pc_q    <= pc_d;
            valid_q <= 1'b0;
            state_q <= FETCH;
          end
        end
        MEMWAIT: begin
          if (dhit) begin
            valid_q <= 1'b0;
            state_q <= FETCH;
          end
        end
        default: begin
          halted_q <= 1'b1;
          state_q  <= HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, branches, jumps, memory stall,
// halt, reset priority and PC wrap-around.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] imemaddr;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [2:0]  PCSrc;
  logic [31:0] jr_target;
  logic        mem_op;
  logic        dhit;
  logic        halt;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        commit;
  logic        halted;

  int vectors = 0;
  int miscompares = 0;

  fetch_unit #(.PC_INIT(32'h0000_0000)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload), .iREN(iREN),
    .imemaddr(imemaddr), .instruction(instruction), .instr_valid(instr_valid),
    .PCSrc(PCSrc), .jr_target(jr_target), .mem_op(mem_op), .dhit(dhit),
    .halt(halt), .pc(pc), .pc_plus4(pc_plus4), .commit(commit), .halted(halted)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // From FETCH: fetch one word with a zero-wait hit, then leave EXEC with the given PCSrc.
  task automatic run_instr(input logic [31:0] ins, input logic [2:0] src, input logic [31:0] jr);
    imemload = ins;
    ihit = 1'b1;
    cyc();
    PCSrc = src;
    jr_target = jr;
    cyc();
    PCSrc = 3'd4;
    #1;
  endtask

  initial begin
    RST = 1'b1; ihit = 1'b0; imemload = 32'd0; PCSrc = 3'd4; jr_target = 32'd0;
    mem_op = 1'b0; dhit = 1'b0; halt = 1'b0;
    cyc(); cyc();
    RST = 1'b0;
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_iren", {31'd0, iREN}, 32'd1);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_instr", instruction, 32'h0);
    chk("rst_commit", {31'd0, commit}, 32'd0);

    // Sequential fetch
    ihit = 1'b1; imemload = 32'h1111_1111;
    #1;
    chk("seq_addr0", imemaddr, 32'h0);
    chk("seq_commit_fetch", {31'd0, commit}, 32'd0);
    cyc(); #1;
    chk("seq_instr", instruction, 32'h1111_1111);
    chk("seq_valid", {31'd0, instr_valid}, 32'd1);
    chk("seq_iren_exec", {31'd0, iREN}, 32'd0);
    chk("seq_commit_exec", {31'd0, commit}, 32'd1);
    cyc(); #1;
    chk("seq_addr4", imemaddr, 32'h4);
    chk("seq_commit_f2", {31'd0, commit}, 32'd0);
    chk("seq_valid_f2", {31'd0, instr_valid}, 32'd0);
    cyc(); #1;
    chk("seq_commit_e2", {31'd0, commit}, 32'd1);
    cyc(); #1;
    chk("seq_addr8", imemaddr, 32'h8);

    // Branches at pc=0x10
    run_instr(32'h0, 3'd0, 32'h10);
    chk("jr_0x10", imemaddr, 32'h10);
    run_instr(32'h1000_FFFE, 3'd2, 32'h0);
    chk("br_back", imemaddr, 32'h0C);
    run_instr(32'h0, 3'd0, 32'h10);
    run_instr(32'h1000_0003, 3'd2, 32'h0);
    chk("br_fwd", imemaddr, 32'h20);

    // Jump and jump-register
    run_instr(32'h0, 3'd0, 32'h4000_0000);
    chk("pc_plus4_hi", pc_plus4, 32'h4000_0004);
    run_instr(32'h0800_0100, 3'd1, 32'h0);
    chk("j_target", imemaddr, 32'h4000_0400);
    run_instr(32'h0, 3'd0, 32'h88);
    chk("jr_0x88", imemaddr, 32'h88);

    // Load with three stall cycles
    imemload = 32'h8C00_0000; ihit = 1'b1;
    cyc();
    mem_op = 1'b1;
    #1;
    chk("lw_exec_commit", {31'd0, commit}, 32'd0);
    cyc();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lw_wait_valid", {31'd0, instr_valid}, 32'd1);
      chk("lw_wait_iren", {31'd0, iREN}, 32'd0);
      chk("lw_wait_commit", {31'd0, commit}, 32'd0);
      chk("lw_wait_instr", instruction, 32'h8C00_0000);
      cyc();
    end
    dhit = 1'b1;
    #1;
    chk("lw_dhit_commit", {31'd0, commit}, 32'd1);
    cyc();
    dhit = 1'b0; mem_op = 1'b0;
    #1;
    chk("lw_next_iren", {31'd0, iREN}, 32'd1);
    chk("lw_next_addr", imemaddr, 32'h8C);
    chk("lw_next_valid", {31'd0, instr_valid}, 32'd0);

    // Halt
    ihit = 1'b1;
    cyc();
    halt = 1'b1;
    #1;
    chk("halt_commit", {31'd0, commit}, 32'd0);
    cyc();
    halt = 1'b0; dhit = 1'b1; ihit = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("halt_halted", {31'd0, halted}, 32'd1);
      chk("halt_iren", {31'd0, iREN}, 32'd0);
      chk("halt_pc", pc, 32'h8C);
      chk("halt_commit_hold", {31'd0, commit}, 32'd0);
      cyc();
    end
    dhit = 1'b0;
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    #1;
    chk("halt_rst_pc", pc, 32'h0);
    chk("halt_rst_halted", {31'd0, halted}, 32'd0);
    chk("halt_rst_iren", {31'd0, iREN}, 32'd1);

    // Reset priority over dhit in MEMWAIT and over ihit in FETCH
    ihit = 1'b1;
    cyc();
    mem_op = 1'b1;
    cyc();
    chk("rp_mw_pc", pc, 32'h4);
    dhit = 1'b1; RST = 1'b1;
    #1;
    chk("rp_mw_commit", {31'd0, commit}, 32'd0);
    cyc();
    RST = 1'b0; dhit = 1'b0; mem_op = 1'b0;
    #1;
    chk("rp_mw_pc_after", pc, 32'h0);
    chk("rp_mw_valid", {31'd0, instr_valid}, 32'd0);
    chk("rp_mw_iren", {31'd0, iREN}, 32'd1);
    RST = 1'b1; ihit = 1'b1;
    #1;
    chk("rp_f_commit", {31'd0, commit}, 32'd0);
    cyc();
    RST = 1'b0;
    #1;
    chk("rp_f_valid", {31'd0, instr_valid}, 32'd0);
    chk("rp_f_iren", {31'd0, iREN}, 32'd1);
    chk("rp_f_pc", pc, 32'h0);

    // PC wrap
    run_instr(32'h0, 3'd0, 32'hFFFF_FFFC);
    chk("wrap_addr", imemaddr, 32'hFFFF_FFFC);
    chk("wrap_plus4", pc_plus4, 32'h0);
    run_instr(32'h0, 3'd4, 32'h0);
    chk("wrap_pc", pc, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
